// File: rtl/sent_crc_pkg.sv
// Shared types and constants for the SENT receive CRC engine.
package sent_crc_pkg;

   typedef enum logic [1:0] {
      FAST_AUG    = 2'd0,
      FAST_LEGACY = 2'd1,
      ENH         = 2'd2,
      RSVD        = 2'd3
   } crc_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      AUG  = 2'd2,
      RES  = 2'd3
   } crc_state_e;

   localparam int         CRC4_W     = 4;
   localparam int         CRC6_W     = 6;
   localparam logic [3:0] DEF_SEED4  = 4'b0101;
   localparam logic [5:0] DEF_SEED6  = 6'b010101;
   localparam logic [3:0] DEF_POLY4  = 4'hD;
   localparam logic [5:0] DEF_POLY6  = 6'h19;

   function automatic int crc_width(input crc_mode_e m);
      return (m == ENH) ? CRC6_W : CRC4_W;
   endfunction

endpackage

// File: rtl/sent_crc_nibble_step.sv
// One-nibble (4 unrolled bits, MSB first) CRC step and W-bit zero augmentation.
module sent_crc_nibble_step #(
   parameter int          W    = 4,
   parameter logic [W-1:0] POLY = '0
) (
   input  logic [W-1:0] state_i,
   input  logic [3:0]   nib_i,
   output logic [W-1:0] step_o,
   output logic [W-1:0] aug_o
);

   logic [W-1:0] nib_chain [0:4];
   logic [W-1:0] aug_chain [0:W];

   function automatic logic [W-1:0] bit_step(input logic [W-1:0] s, input logic d);
      return {s[W-2:0], d} ^ (s[W-1] ? POLY : '0);
   endfunction

   assign nib_chain[0] = state_i;
   assign aug_chain[0] = state_i;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_nib
         assign nib_chain[gi+1] = bit_step(nib_chain[gi], nib_i[3-gi]);
      end
      for (genvar gi = 0; gi < W; gi++) begin : g_aug
         assign aug_chain[gi+1] = bit_step(aug_chain[gi], 1'b0);
      end
   endgenerate

   assign step_o = nib_chain[4];
   assign aug_o  = aug_chain[W];

endmodule

// File: rtl/sent_rx_crc_engine.sv
// SENT receive CRC checker: nibble-serial CRC4/CRC6 with result pulse and error counters.
module sent_rx_crc_engine
   import sent_crc_pkg::*;
#(
   parameter int         MAX_NIB = 8,
   parameter logic [3:0] SEED4   = DEF_SEED4,
   parameter logic [5:0] SEED6   = DEF_SEED6,
   parameter logic [3:0] POLY4   = DEF_POLY4,
   parameter logic [5:0] POLY6   = DEF_POLY6,
   parameter int         CNT_W   = 16
) (
   input  logic             clk_rx,
   input  logic             reset_rx,
   input  logic [1:0]       mode_i,
   input  logic [3:0]       nib_i,
   input  logic             nib_valid_i,
   input  logic             nib_last_i,
   input  logic [5:0]       crc_rx_i,
   input  logic             abort_i,
   input  logic             cnt_clr_i,
   output logic             nib_ready_o,
   output logic             busy_o,
   output logic             result_valid_o,
   output logic             crc_ok_o,
   output logic [5:0]       crc_calc_o,
   output logic             len_err_o,
   output logic             mode_err_o,
   output logic [CNT_W-1:0] err_cnt_fast_o,
   output logic [CNT_W-1:0] err_cnt_enh_o
);

   crc_state_e       state_q, state_d;
   crc_mode_e        mode_q, mode_d;
   logic [5:0]       crc_q, crc_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [5:0]       crc_rx_q, crc_rx_d;
   logic             len_flag_q, len_flag_d;
   logic             crc_ok_q, crc_ok_d;
   logic [5:0]       calc_q, calc_d;
   logic             len_err_q, len_err_d;
   logic             mode_err_q, mode_err_d;
   logic [CNT_W-1:0] err_fast_q, err_fast_d;
   logic [CNT_W-1:0] err_enh_q, err_enh_d;

   // In IDLE the first nibble is stepped against the seed of the incoming mode.
   crc_mode_e  step_mode;
   logic [3:0] st4_in, step4, aug4;
   logic [5:0] st6_in, step6, aug6;
   logic [5:0] step_val, aug_final;
   logic       accept, is_idle, aug_match;

   assign is_idle   = (state_q == IDLE);
   assign step_mode = is_idle ? crc_mode_e'(mode_i) : mode_q;
   assign st4_in    = is_idle ? SEED4 : crc_q[3:0];
   assign st6_in    = is_idle ? SEED6 : crc_q;

   sent_crc_nibble_step #(.W(CRC4_W), .POLY(POLY4)) u_step4 (
      .state_i (st4_in),
      .nib_i   (nib_i),
      .step_o  (step4),
      .aug_o   (aug4)
   );

   sent_crc_nibble_step #(.W(CRC6_W), .POLY(POLY6)) u_step6 (
      .state_i (st6_in),
      .nib_i   (nib_i),
      .step_o  (step6),
      .aug_o   (aug6)
   );

   assign step_val  = (crc_width(step_mode) == CRC6_W) ? step6 : {2'b00, step4};
   assign aug_final = (mode_q == FAST_AUG) ? {2'b00, aug4} :
                      (mode_q == ENH)      ? aug6 : crc_q;
   assign aug_match = (mode_q == ENH) ? (aug_final == crc_rx_q)
                                      : (aug_final[3:0] == crc_rx_q[3:0]);

   assign nib_ready_o = (state_q == IDLE) || (state_q == ACC);
   assign accept      = nib_valid_i && nib_ready_o;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      crc_d      = crc_q;
      cnt_d      = cnt_q;
      crc_rx_d   = crc_rx_q;
      len_flag_d = len_flag_q;
      crc_ok_d   = crc_ok_q;
      calc_d     = calc_q;
      len_err_d  = len_err_q;
      mode_err_d = mode_err_q;
      err_fast_d = err_fast_q;
      err_enh_d  = err_enh_q;

      unique case (state_q)
         IDLE: begin
            if (accept && !abort_i) begin
               mode_d     = crc_mode_e'(mode_i);
               crc_d      = step_val;
               cnt_d      = 4'd1;
               len_flag_d = 1'b0;
               if (nib_last_i) begin
                  crc_rx_d = crc_rx_i;
                  state_d  = AUG;
               end else begin
                  state_d  = ACC;
               end
            end
         end
         ACC: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (accept) begin
               crc_d = step_val;
               if (nib_last_i) begin
                  crc_rx_d = crc_rx_i;
                  state_d  = AUG;
               end else if (cnt_q == 4'(MAX_NIB)) begin
                  len_flag_d = 1'b1;
                  state_d    = AUG;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         AUG: begin
            if (abort_i) begin
               state_d = IDLE;
            end else begin
               crc_d      = aug_final;
               calc_d     = aug_final;
               len_err_d  = len_flag_q;
               mode_err_d = (mode_q == RSVD);
               crc_ok_d   = aug_match && !len_flag_q && (mode_q != RSVD);
               state_d    = RES;
            end
         end
         RES: begin
            state_d = IDLE;
            if (!crc_ok_q && !mode_err_q) begin
               if (mode_q == ENH) begin
                  if (err_enh_q != '1) err_enh_d = err_enh_q + 1'b1;
               end else begin
                  if (err_fast_q != '1) err_fast_d = err_fast_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Clearing takes priority over an increment in the same cycle.
      if (cnt_clr_i) begin
         err_fast_d = '0;
         err_enh_d  = '0;
      end
   end

   always_ff @(posedge clk_rx) begin
      if (reset_rx) begin
         state_q    <= IDLE;
         mode_q     <= FAST_AUG;
         crc_q      <= '0;
         cnt_q      <= '0;
         crc_rx_q   <= '0;
         len_flag_q <= 1'b0;
         crc_ok_q   <= 1'b0;
         calc_q     <= '0;
         len_err_q  <= 1'b0;
         mode_err_q <= 1'b0;
         err_fast_q <= '0;
         err_enh_q  <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         crc_q      <= crc_d;
         cnt_q      <= cnt_d;
         crc_rx_q   <= crc_rx_d;
         len_flag_q <= len_flag_d;
         crc_ok_q   <= crc_ok_d;
         calc_q     <= calc_d;
         len_err_q  <= len_err_d;
         mode_err_q <= mode_err_d;
         err_fast_q <= err_fast_d;
         err_enh_q  <= err_enh_d;
      end
   end

   assign busy_o         = !is_idle;
   assign result_valid_o = (state_q == RES);
   assign crc_ok_o       = crc_ok_q;
   assign crc_calc_o     = calc_q;
   assign len_err_o      = len_err_q;
   assign mode_err_o     = mode_err_q;
   assign err_cnt_fast_o = err_fast_q;
   assign err_cnt_enh_o  = err_enh_q;

endmodule

// File: tb/tb_sent_rx_crc_engine.sv
// Directed bench for sent_rx_crc_engine with hand-computed CRC expectations.
module tb_sent_rx_crc_engine;

   localparam int CW = 3;

   logic          clk_rx = 1'b0;
   logic          reset_rx;
   logic [1:0]    mode_i;
   logic [3:0]    nib_i;
   logic          nib_valid_i;
   logic          nib_last_i;
   logic [5:0]    crc_rx_i;
   logic          abort_i;
   logic          cnt_clr_i;
   logic          nib_ready_o;
   logic          busy_o;
   logic          result_valid_o;
   logic          crc_ok_o;
   logic [5:0]    crc_calc_o;
   logic          len_err_o;
   logic          mode_err_o;
   logic [CW-1:0] err_cnt_fast_o;
   logic [CW-1:0] err_cnt_enh_o;

   int n_cmp = 0;
   int n_err = 0;

   sent_rx_crc_engine #(.MAX_NIB(8), .CNT_W(CW)) dut (
      .clk_rx         (clk_rx),
      .reset_rx       (reset_rx),
      .mode_i         (mode_i),
      .nib_i          (nib_i),
      .nib_valid_i    (nib_valid_i),
      .nib_last_i     (nib_last_i),
      .crc_rx_i       (crc_rx_i),
      .abort_i        (abort_i),
      .cnt_clr_i      (cnt_clr_i),
      .nib_ready_o    (nib_ready_o),
      .busy_o         (busy_o),
      .result_valid_o (result_valid_o),
      .crc_ok_o       (crc_ok_o),
      .crc_calc_o     (crc_calc_o),
      .len_err_o      (len_err_o),
      .mode_err_o     (mode_err_o),
      .err_cnt_fast_o (err_cnt_fast_o),
      .err_cnt_enh_o  (err_cnt_enh_o)
   );

   always #5 clk_rx = ~clk_rx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives count nibbles back to back; returns #1 after the last accept edge.
   task automatic send(input logic [1:0] mode, input int count, input logic [3:0] nib,
                       input int flip, input logic last, input logic [5:0] crc);
      for (int i = 0; i < count; i++) begin
         mode_i      = mode;
         nib_i       = (i == flip) ? (nib ^ 4'h1) : nib;
         nib_valid_i = 1'b1;
         nib_last_i  = last && (i == count - 1);
         crc_rx_i    = crc;
         @(posedge clk_rx); #1;
      end
      nib_valid_i = 1'b0;
      nib_last_i  = 1'b0;
   endtask

   // Called right after the last accept (cycle t): checks t+1, t+2 and t+3.
   task automatic expect_result(input string tag, input logic ok, input logic do_calc,
                                input logic [5:0] calc, input logic len, input logic merr);
      @(negedge clk_rx);
      chk({tag, "_rv_t1"}, result_valid_o, 1'b0);
      chk({tag, "_busy_t1"}, busy_o, 1'b1);
      @(negedge clk_rx);
      chk({tag, "_rv_t2"}, result_valid_o, 1'b1);
      chk({tag, "_ok"}, crc_ok_o, ok);
      if (do_calc) chk({tag, "_calc"}, crc_calc_o, calc);
      chk({tag, "_len"}, len_err_o, len);
      chk({tag, "_merr"}, mode_err_o, merr);
      @(posedge clk_rx); #1;
      chk({tag, "_rv_t3"}, result_valid_o, 1'b0);
      chk({tag, "_ready_t3"}, nib_ready_o, 1'b1);
      $display("frame %s: ok=%0d calc=%02h len=%0d merr=%0d fast=%0d enh=%0d",
               tag, crc_ok_o, crc_calc_o, len_err_o, mode_err_o, err_cnt_fast_o, err_cnt_enh_o);
   endtask

   initial begin
      reset_rx    = 1'b1;
      mode_i      = 2'd0;
      nib_i       = 4'h0;
      nib_valid_i = 1'b0;
      nib_last_i  = 1'b0;
      crc_rx_i    = 6'h00;
      abort_i     = 1'b0;
      cnt_clr_i   = 1'b0;
      repeat (3) @(posedge clk_rx);
      #1 reset_rx = 1'b0;

      chk("rst_ready", nib_ready_o, 1'b1);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_rv", result_valid_o, 1'b0);
      chk("rst_ok", crc_ok_o, 1'b0);
      chk("rst_calc", crc_calc_o, 6'h00);
      chk("rst_len", len_err_o, 1'b0);
      chk("rst_merr", mode_err_o, 1'b0);
      chk("rst_fast", err_cnt_fast_o, 3'd0);
      chk("rst_enh", err_cnt_enh_o, 3'd0);

      // Six zero nibbles: augmented CRC4 returns to the seed, legacy gives F.
      send(2'd0, 6, 4'h0, -1, 1'b1, 6'h05);
      expect_result("m0_zero", 1'b1, 1'b1, 6'h05, 1'b0, 1'b0);
      send(2'd1, 6, 4'h0, -1, 1'b1, 6'h0F);
      expect_result("m1_zero", 1'b1, 1'b1, 6'h0F, 1'b0, 1'b0);
      send(2'd1, 6, 4'h0, -1, 1'b1, 6'h05);
      expect_result("m1_bad", 1'b0, 1'b1, 6'h0F, 1'b0, 1'b0);
      chk("fast_after_m1_bad", err_cnt_fast_o, 3'd1);

      send(2'd2, 6, 4'h0, -1, 1'b1, 6'h26);
      expect_result("m2_zero", 1'b1, 1'b1, 6'h26, 1'b0, 1'b0);
      send(2'd2, 6, 4'h0, 3, 1'b1, 6'h26);
      expect_result("m2_flip", 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      chk("enh_after_flip", err_cnt_enh_o, 3'd1);
      chk("fast_after_flip", err_cnt_fast_o, 3'd1);

      // Nine nibbles without last, then a frame started exactly at t+3.
      send(2'd0, 9, 4'h0, -1, 1'b0, 6'h00);
      expect_result("len_err", 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      send(2'd0, 6, 4'h0, -1, 1'b1, 6'h05);
      expect_result("b2b", 1'b1, 1'b1, 6'h05, 1'b0, 1'b0);
      chk("fast_after_len", err_cnt_fast_o, 3'd2);

      // Abort in ACC after the third nibble.
      send(2'd0, 3, 4'h0, -1, 1'b0, 6'h00);
      chk("abort_busy_before", busy_o, 1'b1);
      abort_i = 1'b1;
      @(posedge clk_rx); #1;
      abort_i = 1'b0;
      chk("abort_busy_after", busy_o, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_rx);
         chk("abort_no_rv", result_valid_o, 1'b0);
      end
      @(posedge clk_rx); #1;
      $display("abort: busy=%0d rv=%0d", busy_o, result_valid_o);
      send(2'd0, 6, 4'h0, -1, 1'b1, 6'h05);
      expect_result("post_abort", 1'b1, 1'b1, 6'h05, 1'b0, 1'b0);
      chk("fast_after_abort", err_cnt_fast_o, 3'd2);

      // Abort in IDLE drops the nibble offered in the same cycle.
      abort_i = 1'b1;
      send(2'd0, 1, 4'h0, -1, 1'b1, 6'h03);
      abort_i = 1'b0;
      chk("idle_abort_busy", busy_o, 1'b0);
      $display("idle abort: busy=%0d", busy_o);

      // Reserved mode: one zero nibble holds at 3; mismatching crc_rx must not count.
      send(2'd3, 1, 4'h0, -1, 1'b1, 6'h00);
      expect_result("m3", 1'b0, 1'b1, 6'h03, 1'b0, 1'b1);
      chk("fast_after_m3", err_cnt_fast_o, 3'd2);
      chk("enh_after_m3", err_cnt_enh_o, 3'd1);

      // Saturation: single zero nibble in legacy mode gives 3, crc_rx 0 fails.
      for (int k = 1; k <= 6; k++) begin
         send(2'd1, 1, 4'h0, -1, 1'b1, 6'h00);
         expect_result("sat", 1'b0, 1'b1, 6'h03, 1'b0, 1'b0);
         chk("sat_fast", err_cnt_fast_o, (2 + k > 7) ? 3'd7 : 3'(2 + k));
      end

      // Clear during the RES cycle of a failing frame wins over the increment.
      send(2'd1, 1, 4'h0, -1, 1'b1, 6'h00);
      @(posedge clk_rx); #1;
      chk("clr_rv", result_valid_o, 1'b1);
      cnt_clr_i = 1'b1;
      @(posedge clk_rx); #1;
      cnt_clr_i = 1'b0;
      chk("clr_fast", err_cnt_fast_o, 3'd0);
      chk("clr_enh", err_cnt_enh_o, 3'd0);
      $display("clear: fast=%0d enh=%0d", err_cnt_fast_o, err_cnt_enh_o);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
